// File: rtl/phase_loader_if.sv
// Host byte-stream link into the phase loader: a plain valid/ready byte channel.
interface phase_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/phase_loader.sv
// Parses host frames into shadow offset/divide registers and, on COMMIT, copies them to the
// active outputs while holding every divider in reset so all channels restart together.
module phase_loader #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned CHANNELS   = 16,
  parameter int unsigned DEF_DIVIDE = 624,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  phase_loader_if.slave             host,
  output logic [CHANNELS*WIDTH-1:0] offsets,
  output logic [WIDTH-1:0]          divide,
  output logic                      div_rst_n,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic [2:0] {StIdle, StHi, StLo, StApply, StPulse} state_e;

  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned PW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e           r_state, w_state_nxt;
  logic [1:0]       r_op;
  logic [5:0]       r_ch;
  logic [7:0]       r_hi;
  logic [WIDTH-1:0] r_shadow_off [CHANNELS];
  logic [WIDTH-1:0] r_shadow_div;
  logic [PW-1:0]    r_cnt;
  logic [TW-1:0]    r_tmo;

  logic             w_accept, w_in_frame, w_timeout, w_ch_ok, w_off_ok, w_div_ok, w_reject;
  logic [15:0]      w_word;
  logic [WIDTH-1:0] w_val, w_max_off;

  assign w_accept   = host.in_valid & host.in_ready;
  assign w_in_frame = (r_state == StHi) || (r_state == StLo);
  assign w_word     = {r_hi, host.in_data};
  assign w_val      = w_word[WIDTH-1:0];
  assign w_ch_ok    = 32'(r_ch) < CHANNELS;
  assign w_off_ok   = w_ch_ok && (w_val <= r_shadow_div);
  assign w_div_ok   = w_val >= w_max_off;
  assign w_timeout  = w_in_frame && !w_accept && (r_tmo == TW'(TIMEOUT - 1));

  // A new divide must still cover every stored offset.
  always_comb begin
    w_max_off = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (r_shadow_off[i] > w_max_off) w_max_off = r_shadow_off[i];
    end
  end

  always_comb begin
    w_reject = w_timeout;
    if (w_accept && r_state == StIdle && host.in_data[7:6] == 2'b11) w_reject = 1'b1;
    if (w_accept && r_state == StLo) begin
      if (r_op == 2'b00 && !w_off_ok) w_reject = 1'b1;
      if (r_op == 2'b01 && !w_div_ok) w_reject = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StPulse;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          case (host.in_data[7:6])
            2'b00, 2'b01: w_state_nxt = StHi;
            2'b10:        w_state_nxt = StApply;
            default:      w_state_nxt = StIdle;
          endcase
        end
      end
      StHi:    if (w_accept) w_state_nxt = StLo; else if (w_timeout) w_state_nxt = StIdle;
      StLo:    if (w_accept || w_timeout) w_state_nxt = StIdle;
      StApply: w_state_nxt = StPulse;
      StPulse: if (r_cnt == '0) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    host.in_ready = 1'b0;
    busy          = 1'b0;
    unique case (r_state)
      StIdle, StHi, StLo: host.in_ready = 1'b1;
      StApply, StPulse:   busy = 1'b1;
      default:            ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op         <= '0;
      r_ch         <= '0;
      r_hi         <= '0;
      r_shadow_off <= '{default: '0};
      r_shadow_div <= WIDTH'(DEF_DIVIDE);
      r_cnt        <= PW'(RST_CYCLES - 1);
      r_tmo        <= '0;
      offsets      <= '0;
      divide       <= WIDTH'(DEF_DIVIDE);
      div_rst_n    <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= w_reject;
      if (w_accept || !w_in_frame || w_timeout) r_tmo <= '0;
      else                                      r_tmo <= r_tmo + 1'b1;
      if (w_accept && r_state == StIdle) begin
        r_op <= host.in_data[7:6];
        r_ch <= host.in_data[5:0];
      end
      if (w_accept && r_state == StHi) r_hi <= host.in_data;
      if (w_accept && r_state == StLo) begin
        if (r_op == 2'b00 && w_off_ok) r_shadow_off[r_ch[CW-1:0]] <= w_val;
        if (r_op == 2'b01 && w_div_ok) r_shadow_div <= w_val;
      end
      if (r_state == StApply) begin
        for (int unsigned i = 0; i < CHANNELS; i++) offsets[i*WIDTH +: WIDTH] <= r_shadow_off[i];
        divide    <= r_shadow_div;
        div_rst_n <= 1'b0;
        r_cnt     <= PW'(RST_CYCLES - 1);
      end
      if (r_state == StPulse) begin
        if (r_cnt == '0) div_rst_n <= 1'b1;
        else             r_cnt     <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_loader.sv
// Randomised frame stimulus against a shadow/active register model; a negedge monitor pops
// expected err pulses and commit snapshots from a queue as the DUT produces them.
module tb_phase_loader;
  localparam int unsigned WIDTH      = 10;
  localparam int unsigned CHANNELS   = 16;
  localparam int unsigned DEF_DIVIDE = 624;
  localparam int unsigned RST_CYCLES = 4;
  localparam int unsigned TIMEOUT    = 50000;
  localparam int          KErr       = 1;
  localparam int          KCommit    = 2;

  typedef struct {
    int                        kind;
    logic [CHANNELS*WIDTH-1:0] offs;
    logic [WIDTH-1:0]          div;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CHANNELS*WIDTH-1:0] offsets;
  logic [WIDTH-1:0]          divide;
  logic                      div_rst_n, busy, err;

  phase_loader_if hif ();

  phase_loader #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEF_DIVIDE(DEF_DIVIDE),
    .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .host(hif), .offsets(offsets), .divide(divide),
    .div_rst_n(div_rst_n), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 0;
  exp_t expq[$];
  int   m_soff[CHANNELS];
  int   m_aoff[CHANNELS];
  int   m_sdiv, m_adiv;

  task automatic chk(input string nm, input logic [CHANNELS*WIDTH-1:0] act,
                     input logic [CHANNELS*WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CHANNELS*WIDTH-1:0] pack(input int a[CHANNELS]);
    logic [CHANNELS*WIDTH-1:0] v = '0;
    for (int i = 0; i < int'(CHANNELS); i++) v[i*WIDTH +: WIDTH] = a[i][WIDTH-1:0];
    return v;
  endfunction

  function automatic int m_max();
    int m = 0;
    for (int i = 0; i < int'(CHANNELS); i++) if (m_soff[i] > m) m = m_soff[i];
    return m;
  endfunction

  task automatic push(input int kind);
    exp_t e;
    e.kind = kind;
    e.offs = pack(m_soff);
    e.div  = m_sdiv[WIDTH-1:0];
    expq.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] b);
    bit acc = 0;
    int n   = 0;
    hif.in_data  = b;
    hif.in_valid = 1'b1;
    while (!acc && n < 200) begin
      acc = hif.in_ready;
      @(negedge clk);
      n++;
    end
    hif.in_valid = 1'b0;
    chk("byte_accepted", 256'(acc), 256'(1));
  endtask

  task automatic set_frame(input int op, input int ch, input int raw);
    int         v = raw & ((1 << WIDTH) - 1);
    bit         ok;
    logic [7:0] b0;
    if (op == 0) ok = (ch < int'(CHANNELS)) && (v <= m_sdiv);
    else         ok = (v >= m_max());
    if (!ok)          push(KErr);
    else if (op == 0) m_soff[ch] = v;
    else              m_sdiv = v;
    b0 = {op[1:0], ch[5:0]};
    send(b0);
    send(raw[15:8]);
    send(raw[7:0]);
    chk("active_offsets_hold", offsets, pack(m_aoff));
    chk("active_divide_hold", 256'(divide), 256'(m_adiv));
  endtask

  task automatic commit();
    push(KCommit);
    m_aoff = m_soff;
    m_adiv = m_sdiv;
    send(8'h80);
  endtask

  task automatic model_reset();
    foreach (m_soff[i]) begin
      m_soff[i] = 0;
      m_aoff[i] = 0;
    end
    m_sdiv = DEF_DIVIDE;
    m_adiv = DEF_DIVIDE;
    expq.delete();
  endtask

  // Entered at a negedge with rst low; releases reset and checks the power-on pulse.
  task automatic por_check(input bit hold_commit);
    chk("rst_offsets", offsets, '0);
    chk("rst_divide", 256'(divide), 256'(DEF_DIVIDE));
    chk("rst_div_rst_n", 256'(div_rst_n), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_ready", 256'(hif.in_ready), 256'(0));
    if (hold_commit) begin
      hif.in_data  = 8'h80;
      hif.in_valid = 1'b1;
    end
    rst = 1'b1;
    for (int i = 1; i <= int'(RST_CYCLES); i++) begin
      @(negedge clk);
      chk("por_div_rst_n", 256'(div_rst_n), 256'(i == int'(RST_CYCLES)));
      chk("por_ready", 256'(hif.in_ready), 256'(i == int'(RST_CYCLES)));
      chk("por_busy", 256'(busy), 256'(i != int'(RST_CYCLES)));
    end
    chk("por_divide", 256'(divide), 256'(DEF_DIVIDE));
    mon_en = 1;
  endtask

  // Monitor: every err pulse and every div_rst_n fall must match the next queued expectation.
  initial begin : monitor
    bit                        prev_drn = 1'b0;
    int                        low_cnt  = 0;
    logic [CHANNELS*WIDTH-1:0] snap;
    exp_t                      e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (err) begin
          if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_err: got err=1, expected no event (t=%0t)", $time);
          end else begin
            e = expq.pop_front();
            chk("err_event_kind", 256'(e.kind), 256'(KErr));
          end
        end
        if (prev_drn && !div_rst_n) begin
          if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_commit: got div_rst_n fall, expected none (t=%0t)", $time);
          end else begin
            e = expq.pop_front();
            chk("commit_event_kind", 256'(e.kind), 256'(KCommit));
            chk("commit_offsets", offsets, e.offs);
            chk("commit_divide", 256'(divide), 256'(e.div));
          end
          snap    = offsets;
          low_cnt = 1;
          chk("pulse_busy", 256'(busy), 256'(1));
        end else if (!div_rst_n && low_cnt > 0) begin
          low_cnt++;
          chk("pulse_offsets_stable", offsets, snap);
          chk("pulse_busy", 256'(busy), 256'(1));
          chk("pulse_not_ready", 256'(hif.in_ready), 256'(0));
        end else if (!prev_drn && div_rst_n && low_cnt > 0) begin
          chk("pulse_length", 256'(low_cnt), 256'(RST_CYCLES));
          chk("pulse_end_busy", 256'(busy), 256'(0));
          low_cnt = 0;
        end
      end else begin
        low_cnt = 0;
      end
      prev_drn = div_rst_n;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    int r;
    hif.in_data  = '0;
    hif.in_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    por_check(0);

    // Offset staged in shadow, only visible after COMMIT.
    set_frame(0, 3, 16'h012C);
    commit();

    // Rejections: offset above divide, channel out of range, reserved opcode.
    set_frame(0, 5, 700);
    set_frame(0, 20, 10);
    push(KErr);
    send(8'hC5);
    set_frame(0, 5, 100);
    commit();

    // Divide below a stored offset is refused; a covering divide goes live on COMMIT.
    set_frame(1, 0, 200);
    commit();
    set_frame(1, 0, 400);
    chk("divide_before_commit", 256'(divide), 256'(DEF_DIVIDE));
    commit();

    // Random frames.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      set_frame(0, $urandom_range(0, 19), $urandom_range(0, 65535));
      else if (r <= 6) set_frame(1, 0, $urandom_range(0, 65535));
      else if (r <= 8) commit();
      else begin
        push(KErr);
        send(8'hC0 | 8'($urandom_range(0, 63)));
      end
    end
    commit();

    // Stalled frame is dropped after TIMEOUT idle cycles.
    push(KErr);
    send(8'h01);
    send(8'h00);
    k = 0;
    while (!err && k < int'(TIMEOUT) + 10) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_cycles", 256'(k), 256'(TIMEOUT));
    chk("timeout_ready", 256'(hif.in_ready), 256'(1));
    set_frame(0, 1, 5);
    commit();

    // Reset during the commit pulse.
    set_frame(0, 7, 77);
    commit();
    k = 0;
    while (div_rst_n && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("pulse_seen_before_reset", 256'(div_rst_n), 256'(0));
    @(negedge clk);
    mon_en = 0;
    rst    = 1'b0;
    model_reset();
    @(negedge clk);
    push(KCommit);
    por_check(1);
    send(8'h80);

    // Reset mid-frame, then a fresh frame must parse cleanly.
    send(8'h02);
    send(8'h01);
    mon_en = 0;
    rst    = 1'b0;
    model_reset();
    @(negedge clk);
    por_check(0);
    set_frame(0, 2, 50);
    commit();

    repeat (RST_CYCLES + 4) @(negedge clk);
    chk("final_offsets", offsets, pack(m_aoff));
    chk("final_divide", 256'(divide), 256'(m_adiv));
    chk("expectations_drained", 256'(expq.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
